multi_timer: RTL and testbench
==============================

MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, the number of independent timer channels (1..16).
REQ-002 The block SHALL have parameter WIDTH, default 16, the period/counter width in bits (2..32).
REQ-003 The block SHALL have parameter DEFAULT_PERIOD, default 10, the period loaded into every channel at reset.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  N_CH  per-channel start/restart pulse.
REQ-007 stop  input  N_CH  per-channel stop pulse.
REQ-008 oneshot  input  N_CH  per-channel mode, sampled only when start is high: 1 = one-shot, 0 = periodic.
REQ-009 ld_valid  input  1  period-load strobe.
REQ-010 ld_ch  input  clog2(N_CH) (min 1)  channel index for the load.
REQ-011 ld_period  input  WIDTH  new period value in clk cycles.
REQ-012 tick  output  N_CH  registered one-cycle pulse per channel expiry.
REQ-013 running  output  N_CH  registered per-channel run status.

Function
REQ-014 Each channel SHALL hold: an active period, a pending period, a pending flag, a counter cnt, a mode bit and a run bit.
REQ-015 Channel behaviour SHALL be as follows.
- Start sampled at edge E0: run=1, cnt=0, mode latched.
- While run=1: cnt increments by 1 each edge.
- At the edge where cnt==P-1 (P = active period): cnt returns to 0 and tick is 1 for exactly one cycle.
- Result: first tick follows edge E_P, then one tick every P cycles.
REQ-016 P=1 SHALL produce tick high in every cycle after E1; P=0 SHALL be treated as "never expire": run=1, no tick, cnt held at 0.
REQ-017 In one-shot mode the expiry edge SHALL also clear run, so exactly one tick is produced; periodic mode SHALL keep run=1.
REQ-018 A stop pulse SHALL clear run and cnt at the next edge with no tick that cycle, even if cnt==P-1.
REQ-019 Start and stop high together on a channel SHALL resolve to stop.
REQ-020 Start on a running channel SHALL restart it: cnt=0, mode re-latched, and no tick that cycle, even if cnt==P-1.
REQ-021 A load to an idle channel (run=0) SHALL write the active period directly at the next edge.
REQ-022 A load to a running channel SHALL write the pending period and set the pending flag; the pending period SHALL become active at the channel's next expiry edge, or at a start edge, whichever comes first.
REQ-023 A later load before transfer SHALL overwrite the pending value, last one wins.
REQ-024 Load with ld_ch >= N_CH SHALL be ignored.
REQ-025 A load coinciding with a start on the same channel SHALL make the loaded value active for the started run.
REQ-026 The counter SHALL never exceed P-1; all arithmetic SHALL be WIDTH-bit unsigned with no overflow possible.
REQ-027 Channels SHALL be fully independent; simultaneous events on different channels SHALL each behave as if alone.

Reset
REQ-028 With rst high at an edge, every channel SHALL go to: tick=0, running=0, cnt=0, active period=DEFAULT_PERIOD, pending flag=0, mode=periodic.
REQ-029 Reset SHALL override start, stop and ld_valid in the same cycle; assertion mid-count SHALL abort with no tick.

Structure
REQ-030 Mode encodings and the default parameter values SHALL live in a shared package (multi_timer_pkg), along with the channel-index width helper.
REQ-031 One sub-module, timer_channel, SHALL implement a single channel; multi_timer SHALL instantiate N_CH copies and decode the load strobe per channel.

Verification
REQ-032 The bench SHALL run with N_CH=4, WIDTH=16, DEFAULT_PERIOD=10 and cover the following scenarios.
- Reset released, start[0] pulsed periodic -> tick[0] after edges 10, 20, 30, …; running[0]=1; other channels silent.
- Load ch1=3, start[1] oneshot=1 -> single tick[1] after edge 3, running[1]=0 from that same edge, no further ticks.
- ch2 running at P=10, load 4 at cnt=5 -> next tick still at cnt 9, subsequent ticks every 4 cycles.
- ch3 P=1 periodic -> tick[3] high continuously; stop and start asserted together -> running[3]=0 and ticks cease.
- Restart ch0 at cnt=9 -> no tick that cycle, next tick 10 cycles later.
- rst asserted mid-count on all channels -> all outputs 0; restart shows period 10.
- ld_ch=5 written (invalid index) -> no channel period changes.

Source files
------------

// File: rtl/multi_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_timer_pkg
// Description : Shared definitions for the multi-channel timer. This package
//               holds the channel mode encoding, the default parameter values
//               and the helper that sizes the load channel-index field.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_timer_pkg;

    localparam int c_DEFAULT_N_CH   = 4;
    localparam int c_DEFAULT_WIDTH  = 16;
    localparam int c_DEFAULT_PERIOD = 10;

    // Channel run mode, latched on each start
    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    // Width of the channel-index field. A single-channel timer still
    // gets a 1-bit index, so index 1 is representable and rejected.
    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : multi_timer_pkg
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
// Module      : timer_channel
// Description : One independent timer channel. Counts from 0 to P-1 while
//               running and pulses tick on the wrap edge. It supports
//               one-shot and periodic modes, and it double-buffers period
//               loads that arrive while the channel is running.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start/stop        - start/restart and stop pulses
//               oneshot           - mode, sampled with start
//               ld, ld_period     - period load aimed at this channel
//               tick, running     - registered expiry pulse and run status
// Revision    : 1.0 - initial release
// ============================================================================
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int WIDTH          = c_DEFAULT_WIDTH,
    parameter int DEFAULT_PERIOD = c_DEFAULT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_period,
    output logic             tick,
    output logic             running
);

    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_pend_period;
    logic             r_pend;
    logic [WIDTH-1:0] r_cnt;
    mode_e            r_mode;
    logic             r_run;
    logic             r_tick;

    logic             w_start_eff;
    logic             w_expire;

    // Stop wins over start. A start also blocks expiry, so a restart on
    // the wrap cycle does not produce a tick.
    assign w_start_eff = start && !stop;
    assign w_expire    = r_run && !start && !stop &&
                         (r_period != '0) && (r_cnt == r_period - WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period      <= WIDTH'(DEFAULT_PERIOD);
            r_pend_period <= '0;
            r_pend        <= 1'b0;
            r_cnt         <= '0;
            r_mode        <= MODE_PERIODIC;
            r_run         <= 1'b0;
            r_tick        <= 1'b0;
        end else begin
            // ---------------- period bookkeeping ----------------
            if (w_start_eff) begin
                // A same-cycle load takes priority over any pending value.
                if (ld) begin
                    r_period <= ld_period;
                end else if (r_pend) begin
                    r_period <= r_pend_period;
                end
                r_pend <= 1'b0;
            end else if (w_expire) begin
                if (r_pend) begin
                    r_period <= r_pend_period;
                end
                // A load on the expiry edge queues behind the transfer.
                r_pend <= ld;
                if (ld) begin
                    r_pend_period <= ld_period;
                end
            end else if (ld) begin
                if (r_run) begin
                    r_pend_period <= ld_period;
                    r_pend        <= 1'b1;
                end else begin
                    r_period <= ld_period;
                end
            end

            // ---------------- run / count / tick ----------------
            r_tick <= 1'b0;
            if (stop) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else if (start) begin
                r_run  <= 1'b1;
                r_cnt  <= '0;
                r_mode <= oneshot ? MODE_ONESHOT : MODE_PERIODIC;
            end else if (w_expire) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
                if (r_mode == MODE_ONESHOT) begin
                    r_run <= 1'b0;
                end
            end else if (r_run && (r_period != '0)) begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
            // A period of zero keeps the counter parked at 0 forever.
        end
    end

    assign tick    = r_tick;
    assign running = r_run;

endmodule : timer_channel
`default_nettype wire

// File: rtl/multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : multi_timer
// Description : Bank of N_CH independent timer channels. A single shared
//               load port is decoded to the addressed channel. Loads that
//               name a channel index at or above N_CH are dropped.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               start/stop/oneshot[N_CH] - per-channel control
//               ld_valid/ld_ch/ld_period - period load port
//               tick[N_CH]               - one-cycle expiry pulses
//               running[N_CH]            - per-channel run status
// Revision    : 1.0 - initial release
// ============================================================================
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int N_CH           = c_DEFAULT_N_CH,
    parameter int WIDTH          = c_DEFAULT_WIDTH,
    parameter int DEFAULT_PERIOD = c_DEFAULT_PERIOD
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CH-1:0]             start,
    input  logic [N_CH-1:0]             stop,
    input  logic [N_CH-1:0]             oneshot,
    input  logic                        ld_valid,
    input  logic [ch_idx_w(N_CH)-1:0]   ld_ch,
    input  logic [WIDTH-1:0]            ld_period,
    output logic [N_CH-1:0]             tick,
    output logic [N_CH-1:0]             running
);

    logic            w_ld_in_range;
    logic [N_CH-1:0] w_ld;

    assign w_ld_in_range = (int'(ld_ch) < N_CH);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_ld[i] = ld_valid && w_ld_in_range && (int'(ld_ch) == i);

        timer_channel #(
            .WIDTH          (WIDTH),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .start     (start[i]),
            .stop      (stop[i]),
            .oneshot   (oneshot[i]),
            .ld        (w_ld[i]),
            .ld_period (ld_period),
            .tick      (tick[i]),
            .running   (running[i])
        );
    end

endmodule : multi_timer
`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_timer
// Description : Directed self-checking bench for multi_timer. The main
//               instance uses 4 channels, 16-bit counters and a default
//               period of 10. A 5-channel instance provides a load index
//               (5) that fits the port but names no channel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_timer;

    logic        clk;
    logic        rst;
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [3:0]  oneshot;
    logic        ld_valid;
    logic [1:0]  ld_ch;
    logic [15:0] ld_period;
    logic [3:0]  tick;
    logic [3:0]  running;

    logic [4:0]  s5_start;
    logic [4:0]  s5_stop;
    logic [4:0]  s5_oneshot;
    logic        s5_ld_valid;
    logic [2:0]  s5_ld_ch;
    logic [15:0] s5_ld_period;
    logic [4:0]  s5_tick;
    logic [4:0]  s5_running;

    int total;
    int bad;

    multi_timer #(.N_CH(4), .WIDTH(16), .DEFAULT_PERIOD(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .oneshot   (oneshot),
        .ld_valid  (ld_valid),
        .ld_ch     (ld_ch),
        .ld_period (ld_period),
        .tick      (tick),
        .running   (running)
    );

    multi_timer #(.N_CH(5), .WIDTH(16), .DEFAULT_PERIOD(10)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .start     (s5_start),
        .stop      (s5_stop),
        .oneshot   (s5_oneshot),
        .ld_valid  (s5_ld_valid),
        .ld_ch     (s5_ld_ch),
        .ld_period (s5_ld_period),
        .tick      (s5_tick),
        .running   (s5_running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then return to the falling edge for sampling/driving.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [1:0] ch, input logic [15:0] p);
        ld_valid  = 1'b1;
        ld_ch     = ch;
        ld_period = p;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        start = '0; stop = '0; oneshot = '0;
        ld_valid = 1'b0; ld_ch = '0; ld_period = '0;
        s5_start = '0; s5_stop = '0; s5_oneshot = '0;
        s5_ld_valid = 1'b0; s5_ld_ch = '0; s5_ld_period = '0;

        // ---------------- reset ----------------
        cyc(); cyc();
        chk("rst_tick", 32'(tick), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_s5_running", 32'(s5_running), 0);
        rst = 1'b0;

        // ---------------- ch0 periodic, P=10 ----------------
        start = 4'b0001; cyc(); start = '0;
        chk("s1_running", 32'(running), 1);
        chk("s1_tick_e0", 32'(tick), 0);
        for (int k = 1; k <= 30; k++) begin
            cyc();
            chk("s1_tick", 32'(tick), (k % 10 == 0) ? 1 : 0);
        end
        chk("s1_running_after", 32'(running), 1);

        // ---------------- restart ch0 on its wrap cycle ----------------
        for (int k = 1; k <= 9; k++) begin
            cyc();
            chk("s5_pre", 32'(tick), 0);
        end
        start = 4'b0001; cyc(); start = '0;
        chk("s5_restart_notick", 32'(tick), 0);
        chk("s5_restart_running", 32'(running), 1);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk("s5_tick", 32'(tick), (k == 10) ? 1 : 0);
        end
        stop = 4'b0001; cyc(); stop = '0;
        chk("s5_stop_running", 32'(running), 0);
        chk("s5_stop_tick", 32'(tick), 0);

        // ---------------- ch1 one-shot, P=3 ----------------
        load(2'd1, 16'd3); cyc(); ld_valid = 1'b0;
        start = 4'b0010; oneshot = 4'b0010; cyc(); start = '0; oneshot = '0;
        chk("s2_running", 32'(running), 2);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("s2_tick", 32'(tick), (k == 3) ? 2 : 0);
            chk("s2_running_k", 32'(running), (k < 3) ? 2 : 0);
        end

        // ---------------- load coinciding with start on ch1 ----------------
        load(2'd1, 16'd2); start = 4'b0010; cyc();
        ld_valid = 1'b0; start = '0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("s2b_tick", 32'(tick), (k % 2 == 0) ? 2 : 0);
        end
        stop = 4'b0010; cyc(); stop = '0;
        chk("s2b_stop", 32'(running), 0);

        // ---------------- ch2 pending load at cnt=5 ----------------
        start = 4'b0100; cyc(); start = '0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk("s3_pre", 32'(tick), 0);
        end
        load(2'd2, 16'd4); cyc(); ld_valid = 1'b0;
        chk("s3_ld_edge", 32'(tick), 0);
        for (int k = 7; k <= 18; k++) begin
            cyc();
            chk("s3_tick", 32'(tick), (k == 10 || k == 14 || k == 18) ? 4 : 0);
        end
        chk("s3_running", 32'(running), 4);
        stop = 4'b0100; cyc(); stop = '0;

        // ---------------- ch3 P=1, then start+stop together ----------------
        load(2'd3, 16'd1); cyc(); ld_valid = 1'b0;
        start = 4'b1000; cyc(); start = '0;
        chk("s4_tick_e0", 32'(tick), 0);
        chk("s4_running", 32'(running), 8);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk("s4_tick", 32'(tick), 8);
        end
        start = 4'b1000; stop = 4'b1000; cyc(); start = '0; stop = '0;
        chk("s4_both_running", 32'(running), 0);
        chk("s4_both_tick", 32'(tick), 0);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("s4_silent", 32'(tick), 0);
        end

        // ---------------- reset mid-count overrides everything ----------------
        start = 4'b1111; cyc(); start = '0;
        cyc(); cyc();
        rst = 1'b1; start = 4'b1111; load(2'd0, 16'd7); cyc();
        chk("s6_rst_tick", 32'(tick), 0);
        chk("s6_rst_running", 32'(running), 0);
        rst = 1'b0; start = '0; ld_valid = 1'b0;
        start = 4'b1111; cyc(); start = '0;
        chk("s6_running", 32'(running), 15);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk("s6_tick", 32'(tick), (k == 10) ? 15 : 0);
        end
        stop = 4'b1111; cyc(); stop = '0;

        // ---------------- invalid load index on the 5-channel instance ----------------
        s5_ld_valid = 1'b1; s5_ld_ch = 3'd5; s5_ld_period = 16'd2; cyc();
        s5_ld_valid = 1'b0;
        s5_start = 5'b11111; cyc(); s5_start = '0;
        chk("s7_running", 32'(s5_running), 31);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk("s7_tick", 32'(s5_tick), (k == 10) ? 31 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_multi_timer
`default_nettype wire
